// File: rtl/pack_pbits.sv
// Transmit-side framer: snapshots the p-bit state vector on request and streams it
// out as FRAME_COUNT AXI-Stream beats, lowest slice first, with tlast on the final beat.
module pack_pbits #(
    parameter int DATA_WIDTH      = 256,
    parameter int TOTAL_NUM_PBITS = 1024
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [TOTAL_NUM_PBITS-1:0] pbits,
    input  logic                       send_req,
    output logic [DATA_WIDTH-1:0]      s_axis_tx_tdata,
    output logic                       s_axis_tx_tvalid,
    input  logic                       s_axis_tx_tready,
    output logic                       s_axis_tx_tlast,
    output logic                       busy,
    output logic                       frame_done,
    output logic [31:0]                frames_sent
);

    localparam int FRAME_COUNT = TOTAL_NUM_PBITS / DATA_WIDTH;
    localparam int IDX_W       = (FRAME_COUNT > 1) ? $clog2(FRAME_COUNT) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(FRAME_COUNT - 1);

    generate
        if ((TOTAL_NUM_PBITS % DATA_WIDTH) != 0 || FRAME_COUNT < 1) begin : g_bad_params
            $error("pack_pbits: TOTAL_NUM_PBITS must be a non-zero multiple of DATA_WIDTH");
        end
    endgenerate

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_e;

    state_e                                 state_q, state_d;
    logic [FRAME_COUNT-1:0][DATA_WIDTH-1:0] snap_q, snap_d;
    logic [IDX_W-1:0]                       idx_q, idx_d;
    logic                                   pending_q, pending_d;
    logic [DATA_WIDTH-1:0]                  tdata_q, tdata_d;
    logic                                   tvalid_q, tvalid_d;
    logic                                   tlast_q, tlast_d;
    logic                                   busy_q, busy_d;
    logic                                   frame_done_q, frame_done_d;
    logic [31:0]                            frames_sent_q, frames_sent_d;
    logic                                   xfer;
    logic                                   capture;

    assign xfer = tvalid_q && s_axis_tx_tready;

    always_comb begin
        // NOTE: every _d gets a default before any branch so no path leaves it unassigned (no latch).
        state_d       = state_q;
        snap_d        = snap_q;
        idx_d         = idx_q;
        pending_d     = pending_q;
        tdata_d       = tdata_q;
        tvalid_d      = tvalid_q;
        tlast_d       = tlast_q;
        frame_done_d  = 1'b0;
        frames_sent_d = frames_sent_q;
        capture       = 1'b0;

        case (state_q)
            IDLE: begin
                if (send_req) begin
                    capture = 1'b1;
                end
            end
            SEND: begin
                if (xfer && tlast_q) begin
                    frame_done_d  = 1'b1;
                    frames_sent_d = frames_sent_q + 32'd1;
                    // A request on this very edge counts as pending and chains the next frame.
                    if (pending_q || send_req) begin
                        capture   = 1'b1;
                        pending_d = 1'b0;
                    end else begin
                        state_d  = IDLE;
                        tvalid_d = 1'b0;
                        tlast_d  = 1'b0;
                    end
                end else begin
                    if (send_req) begin
                        pending_d = 1'b1;
                    end
                    if (xfer) begin
                        idx_d   = idx_q + IDX_W'(1);
                        tdata_d = snap_q[idx_d];
                        tlast_d = (idx_d == LAST_IDX);
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        // Beat 0 comes straight from pbits since the snapshot is written on the same edge.
        if (capture) begin
            snap_d   = pbits;
            idx_d    = '0;
            tdata_d  = pbits[DATA_WIDTH-1:0];
            tvalid_d = 1'b1;
            tlast_d  = (FRAME_COUNT == 1);
            state_d  = SEND;
        end

        busy_d = (state_d == SEND) || pending_d;
    end

    // NOTE: state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            idx_q         <= '0;
            pending_q     <= 1'b0;
            tdata_q       <= '0;
            tvalid_q      <= 1'b0;
            tlast_q       <= 1'b0;
            busy_q        <= 1'b0;
            frame_done_q  <= 1'b0;
            frames_sent_q <= '0;
        end else begin
            state_q       <= state_d;
            idx_q         <= idx_d;
            pending_q     <= pending_d;
            tdata_q       <= tdata_d;
            tvalid_q      <= tvalid_d;
            tlast_q       <= tlast_d;
            busy_q        <= busy_d;
            frame_done_q  <= frame_done_d;
            frames_sent_q <= frames_sent_d;
        end
    end

    // NOTE: the wide snapshot is a data store with no reset; it is always rewritten before use.
    always_ff @(posedge clk) begin
        snap_q <= snap_d;
    end

    assign s_axis_tx_tdata  = tdata_q;
    assign s_axis_tx_tvalid = tvalid_q;
    assign s_axis_tx_tlast  = tlast_q;
    assign busy             = busy_q;
    assign frame_done       = frame_done_q;
    assign frames_sent      = frames_sent_q;

endmodule
